// File: rtl/tc_register_bank_arbiter.sv
// tc_register_bank_arbiter
// Round-robin sequencer that shares a bank of TC_Register instances between
// several requesters. Writes take one WR cycle (save strobe, register samples
// on negedge); reads take RD_LOAD (load strobe) then RD_CAPT (register drives
// the shared bus, captured at the closing posedge). Every output is either a
// register or a decode of the registered state.

module tc_register_bank_arbiter #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_REQ    = 4,
    parameter int NUM_REG    = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic                            err,
    output logic [BIT_WIDTH-1:0]            rdata,
    output logic                            busy,
    output logic [NUM_REG-1:0]              reg_load,
    output logic [NUM_REG-1:0]              reg_save,
    output logic [BIT_WIDTH-1:0]            reg_in,
    input  logic [BIT_WIDTH-1:0]            reg_out
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_LOAD = 2'd2,
        RD_CAPT = 2'd3
    } state_t;

    state_t               state;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       win_id;
    logic                 win_valid;

    logic                 arb_found;
    logic [IDW-1:0]       arb_id;
    logic [IDW-1:0]       arb_next_ptr;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [BIT_WIDTH-1:0]  wdata_arr [NUM_REQ];

    // Address is valid only when it selects an existing register
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (int'(a) < NUM_REG);
    endfunction

    // One-hot register strobe; all zero for an invalid address
    function automatic logic [NUM_REG-1:0] addr_dec(input logic [ADDR_WIDTH-1:0] a);
        logic [NUM_REG-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            d[i] = (int'(a) == i);
        end
        return d;
    endfunction

    // One-hot requester vector for grant/done pulses
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [IDW-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (int'(id) == i);
        end
        return v;
    endfunction

    // Unpack the per-requester address and data lanes
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*BIT_WIDTH +: BIT_WIDTH];
    end

    // Round-robin pick: first requesting index at or above ptr, wrapping
    always_comb begin
        logic [IDW:0] sum;
        arb_found = 1'b0;
        arb_id    = '0;
        sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NUM_REQ)) begin
                sum = sum - (IDW+1)'(NUM_REQ);
            end
            if (!arb_found && req[sum[IDW-1:0]]) begin
                arb_found = 1'b1;
                arb_id    = sum[IDW-1:0];
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time
    always_comb begin
        if (int'(arb_id) == NUM_REQ - 1) begin
            arb_next_ptr = '0;
        end else begin
            arb_next_ptr = arb_id + IDW'(1);
        end
    end

    assign busy = (state != IDLE);

    // Sequencer: arbitration, bank strobes, completion pulses and read capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            win_id    <= '0;
            win_valid <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            reg_load  <= '0;
            reg_save  <= '0;
            reg_in    <= '0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            reg_load <= '0;
            reg_save <= '0;
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        win_id    <= arb_id;
                        win_valid <= addr_ok(addr_arr[arb_id]);
                        ptr       <= arb_next_ptr;
                        gnt       <= req_onehot(arb_id);
                        if (req_we[arb_id]) begin
                            // reg_in only changes on a write grant so the bus holds its last value
                            reg_in   <= wdata_arr[arb_id];
                            reg_save <= addr_dec(addr_arr[arb_id]);
                            state    <= WR;
                        end else begin
                            reg_load <= addr_dec(addr_arr[arb_id]);
                            state    <= RD_LOAD;
                        end
                    end
                end
                WR: begin
                    done  <= req_onehot(win_id);
                    err   <= !win_valid;
                    state <= IDLE;
                end
                RD_LOAD: begin
                    // Register starts driving reg_out from this closing edge
                    state <= RD_CAPT;
                end
                RD_CAPT: begin
                    rdata <= win_valid ? reg_out : '0;
                    done  <= req_onehot(win_id);
                    err   <= !win_valid;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
